snpu_io_bridge: RTL and testbench
=================================

Name: snpu_io_bridge

Overview:
Parametrised pin-level front end between the 8-bit dedicated/bidirectional pad buses and an SNPU core with N_CH neuron channels. It decodes a byte-serial command stream into configuration writes, run/step control and output paging. It also captures core spikes into sticky flags and presents them on uo_out, 8 channels per page. It sits directly under the top-level pad wrapper, so the core can grow beyond 8 neurons without changing the pinout.

Parameters:
N_CH, 8, number of neuron channels; legal range 1..32; pages = ceil(N_CH/8)
ADDR_W, 5, configuration address width (core register space = 2^ADDR_W bytes)
DATA_W, 8, configuration data width; fixed at 8 in this generation

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, no command is accepted and all state holds
ui_in  in  8  command/data byte; opcode ui_in[7:5], arg ui_in[4:0]
uio_in  in  8  uio_in[0] = cmd_valid; other bits ignored
uo_out  out  8  registered spike page (or readback data, see option)
uio_out  out  8  status: [1] wait_data, [2] run_en, [3] spike_any, [5:4] page, [7:6] 0, [0] 0
uio_oe  out  8  constant 8'hFE
core_spike  in  N_CH  per-channel spike pulses from core, sampled every clk
cfg_rdata  in  8  core register read data for cfg_addr (used only with option)
cfg_we  out  1  one-cycle configuration write strobe
cfg_addr  out  ADDR_W  configuration address
cfg_wdata  out  8  configuration write data
run_en  out  1  core free-run enable
step  out  1  one-cycle single-step pulse

Behaviour:
- Reset (async, rst_n=0) clears every register: uo_out=0, uio_out=0, cfg_we=0, cfg_addr=0, cfg_wdata=0, run_en=0, step=0, page=0, sticky=0, FSM=IDLE. uio_oe=8'hFE at all times, including during reset.
- A byte is accepted on a rising clk edge when ena=1 and uio_in[0]=1. Every cycle meeting this condition is one byte; there is no edge detection.
- FSM IDLE decodes the opcode:
  - 000 NOP.
  - 001 SET_ADDR: cfg_addr <= arg[ADDR_W-1:0].
  - 010 WRITE: go to WAIT_DATA.
  - 011 PAGE: page <= arg mod pages.
  - 100 RUN: run_en <= arg[0].
  - 101 STEP: step=1 for exactly the next cycle.
  - 110 CLEAR: sticky <= 0.
  - 111: see option.
- FSM WAIT_DATA: the next accepted byte, whatever its value, is data.
  - cfg_wdata <= byte and cfg_we=1 for exactly the following cycle, using the current cfg_addr.
  - cfg_addr increments by 1 in the cycle after the write strobe, wrapping 2^ADDR_W-1 -> 0.
  - FSM returns to IDLE.
- wait_data (uio_out[1]) = 1 while in WAIT_DATA. If ena drops in WAIT_DATA, the FSM holds state.
- Sticky flags: sticky <= sticky | core_spike each cycle, independent of ena. If CLEAR coincides with spikes, sticky <= core_spike, so new spikes win.
- uo_out <= sticky[page*8 +: 8], registered (1-cycle latency). Bits at channel index >= N_CH read 0.
- spike_any = |sticky, registered.
- STEP while run_en=1: step still pulses; the core ignores or uses it.
- Simultaneous STEP and reset: reset wins, step=0.
- Latency from an accepted command byte to its effect is 1 cycle for registers and pulses. cfg_we follows the data byte by 1 cycle.

Optional Feature:
Macro SNPU_READBACK_EN.
- Defined: opcode 111 READ sets rd_mode. While rd_mode=1, uo_out <= cfg_rdata (registered) instead of spike data. Any other accepted opcode in IDLE clears rd_mode, and READ itself does not change cfg_addr. uio_out[6] = rd_mode.
- Not defined: opcode 111 acts as NOP, cfg_rdata is unused, uio_out[6]=0.

Test Plan:
- Reset then idle: rst_n low 3 cycles mid-run with run_en=1 -> all outputs 0, uio_oe=8'hFE immediately after rst_n falls.
- Burst write: SET_ADDR 5'd30, WRITE, 8'hA5, WRITE, 8'h3C -> cfg_we pulses twice with (30,A5) and (31,3C); cfg_addr ends at 0 (wrap).
- Spike paging, N_CH=12: pulse core_spike bit 9, then PAGE 1 -> uo_out=8'h02 one cycle after PAGE; PAGE 0 -> uo_out=8'h00; spike_any=1.
- CLEAR collides with a spike on ch 3 in the same cycle -> sticky=ch3 only, uo_out=8'h08 on page 0.
- ena low: cmd_valid=1, ui_in=RUN|1 with ena=0 -> run_en stays 0. In WAIT_DATA with ena=0 -> no cfg_we. Raise ena with data 8'h11 -> single write of 8'h11.
- With SNPU_READBACK_EN: cfg_rdata=8'h5A, READ -> uo_out=8'h5A next cycle. NOP -> spike page restored. Without the macro, READ leaves uo_out showing spikes.

Source files
------------

// File: rtl/snpu_io_bridge.sv
// Byte-serial pad front end for the SNPU core: command decode, config writes, run/step control and paged spike flags.
// Optional macro SNPU_READBACK_EN: opcode 111 switches uo_out to cfg_rdata readback.
module snpu_io_bridge #(
    parameter int N_CH   = 8,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        ui_in,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uo_out,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    input  logic [N_CH-1:0]   core_spike,
    input  logic [DATA_W-1:0] cfg_rdata,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    output logic              run_en,
    output logic              step
);

    localparam int PAGES = (N_CH + 7) / 8;

    localparam logic [2:0] OP_SET_ADDR = 3'b001;
    localparam logic [2:0] OP_WRITE    = 3'b010;
    localparam logic [2:0] OP_PAGE     = 3'b011;
    localparam logic [2:0] OP_RUN      = 3'b100;
    localparam logic [2:0] OP_STEP     = 3'b101;
    localparam logic [2:0] OP_CLEAR    = 3'b110;
    localparam logic [2:0] OP_READ     = 3'b111;

    typedef enum logic {
        IDLE,
        WAIT_DATA
    } state_t;

    state_t            state;
    logic [N_CH-1:0]   sticky;
    logic [1:0]        page;
    logic              spike_any;
    logic              rd_mode;
    logic              accept;
    logic [2:0]        opcode;
    logic [4:0]        arg;
    logic [31:0]       sticky_pad;
    logic [7:0]        page_bits;
    logic [1:0]        page_arg;
    logic              clear_hit;
    logic              unused_bits;

    assign accept    = ena & uio_in[0];
    assign opcode    = ui_in[7:5];
    assign arg       = ui_in[4:0];
    assign clear_hit = accept && (state == IDLE) && (opcode == OP_CLEAR);

    // Zero-extending to 32 bits makes channels beyond N_CH read as 0 on the last page.
    assign sticky_pad = 32'(sticky);
    assign page_bits  = sticky_pad[{page, 3'b000} +: 8];
    assign page_arg   = 2'(32'(arg) % PAGES);

    assign uio_oe  = 8'hFE;
    assign uio_out = {1'b0, rd_mode, page, spike_any, run_en, (state == WAIT_DATA), 1'b0};

`ifdef SNPU_READBACK_EN
    assign unused_bits = ^uio_in[7:1];
`else
    assign rd_mode     = 1'b0;
    assign unused_bits = ^{uio_in[7:1], cfg_rdata};
`endif

    // Pulses (step, cfg_we) self-clear every cycle; the address post-increment follows the write strobe
    // even if ena drops, and an explicit SET_ADDR in that same cycle takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sticky    <= '0;
            page      <= 2'd0;
            spike_any <= 1'b0;
            uo_out    <= 8'h00;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            run_en    <= 1'b0;
            step      <= 1'b0;
`ifdef SNPU_READBACK_EN
            rd_mode   <= 1'b0;
`endif
        end else begin
            step      <= 1'b0;
            cfg_we    <= 1'b0;
            spike_any <= |sticky;

            if (clear_hit) begin
                sticky <= core_spike;
            end else begin
                sticky <= sticky | core_spike;
            end

            if (rd_mode) begin
                uo_out <= cfg_rdata[7:0];
            end else begin
                uo_out <= page_bits;
            end

            if (cfg_we) begin
                cfg_addr <= cfg_addr + ADDR_W'(1);
            end

            if (accept) begin
                case (state)
                    IDLE: begin
`ifdef SNPU_READBACK_EN
                        rd_mode <= (opcode == OP_READ);
`endif
                        case (opcode)
                            OP_SET_ADDR: cfg_addr <= ADDR_W'(arg);
                            OP_WRITE:    state    <= WAIT_DATA;
                            OP_PAGE:     page     <= page_arg;
                            OP_RUN:      run_en   <= arg[0];
                            OP_STEP:     step     <= 1'b1;
                            default: ;
                        endcase
                    end
                    WAIT_DATA: begin
                        cfg_wdata <= ui_in[DATA_W-1:0];
                        cfg_we    <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snpu_io_bridge.sv
// Scoreboard bench for snpu_io_bridge (N_CH=12): directed scenarios, then randomized command/spike traffic.
// Build with SNPU_READBACK_EN defined to exercise the readback opcode.
module tb_snpu_io_bridge;

    localparam int N_CH   = 12;
    localparam int ADDR_W = 5;
    localparam int PAGES  = (N_CH + 7) / 8;
`ifdef SNPU_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic [7:0]        ui_in = 8'h00;
    logic [7:0]        uio_in = 8'h00;
    logic [7:0]        cfg_rdata = 8'h00;
    logic [N_CH-1:0]   core_spike = '0;
    logic [7:0]        uo_out;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              run_en;
    logic              step;

    snpu_io_bridge #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .core_spike(core_spike),
        .cfg_rdata(cfg_rdata), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .run_en(run_en), .step(step)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t wr_q[$];
    int  step_q[$];

    bit          m_wait = 1'b0;
    bit          m_run = 1'b0;
    bit          m_rd = 1'b0;
    bit          m_any = 1'b0;
    bit          m_we_pend = 1'b0;
    int unsigned m_addr = 0;
    int unsigned m_page = 0;
    int unsigned m_sticky = 0;
    logic [7:0]  m_uo = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: interprets each accepted byte as a command and keeps the architectural state as plain integers.
    always @(posedge clk or negedge rst_n) begin : model
        bit          acc;
        int          op;
        int          arg;
        int unsigned nxt_addr;
        if (!rst_n) begin
            m_wait = 0; m_run = 0; m_rd = 0; m_any = 0; m_we_pend = 0;
            m_addr = 0; m_page = 0; m_sticky = 0; m_uo = 8'h00;
            wr_q.delete();
            step_q.delete();
        end else begin
            acc = ena && uio_in[0];
            op  = int'(ui_in[7:5]);
            arg = int'(ui_in[4:0]);
            m_uo  = m_rd ? cfg_rdata : 8'(m_sticky >> (m_page * 8));
            m_any = (m_sticky != 0);
            if (acc && !m_wait && op == 6) m_sticky = int'(core_spike);
            else m_sticky = m_sticky | int'(core_spike);
            nxt_addr  = m_we_pend ? (m_addr + 1) % (1 << ADDR_W) : m_addr;
            m_we_pend = 1'b0;
            if (acc) begin
                if (m_wait) begin
                    m_we_pend = 1'b1;
                    wr_q.push_back('{int'(nxt_addr), int'(ui_in)});
                    m_wait = 1'b0;
                end else begin
                    m_rd = 1'b0;
                    case (op)
                        1: nxt_addr = arg;
                        2: m_wait = 1'b1;
                        3: m_page = arg % PAGES;
                        4: m_run = arg[0];
                        5: step_q.push_back(1);
                        7: m_rd = READBACK;
                        default: ;
                    endcase
                end
            end
            m_addr = nxt_addr;
        end
    end

    // Monitor: compares every output on the falling edge and pops the pulse scoreboards.
    always @(negedge clk) begin : monitor
        wr_t w;
        checkOutput("uo_out", uo_out, m_uo);
        checkOutput("run_en", run_en, m_run);
        checkOutput("cfg_addr", cfg_addr, m_addr);
        checkOutput("uio_out", uio_out, {1'b0, m_rd, 2'(m_page), m_any, m_run, m_wait, 1'b0});
        checkOutput("uio_oe", uio_oe, 8'hFE);
        if (cfg_we || wr_q.size() > 0) begin
            if (wr_q.size() == 0) begin
                checkOutput("cfg_we_unexpected", cfg_we, 0);
            end else begin
                w = wr_q.pop_front();
                checkOutput("cfg_we_pulse", cfg_we, 1);
                checkOutput("wr_addr", cfg_addr, w.addr);
                checkOutput("wr_data", cfg_wdata, w.data);
            end
        end
        if (step || step_q.size() > 0) begin
            if (step_q.size() == 0) begin
                checkOutput("step_unexpected", step, 0);
            end else begin
                void'(step_q.pop_front());
                checkOutput("step_pulse", step, 1);
            end
        end
    end

    task automatic applyStimulus(input bit e, input bit v, input logic [7:0] b, input logic [N_CH-1:0] spk);
        @(negedge clk);
        ena        = e;
        uio_in     = {7'($urandom), v};
        ui_in      = b;
        core_spike = spk;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 8'($urandom), '0);
    endtask

    initial begin
        #2;
        checkOutput("rst_uio_oe", uio_oe, 8'hFE);
        checkOutput("rst_uo_out", uo_out, 8'h00);
        checkOutput("rst_uio_out", uio_out, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Burst write across the address wrap
        applyStimulus(1, 1, 8'h3E, '0);
        applyStimulus(1, 1, 8'h40, '0);
        applyStimulus(1, 1, 8'hA5, '0);
        applyStimulus(1, 1, 8'h40, '0);
        applyStimulus(1, 1, 8'h3C, '0);
        idleCycle();
        checkOutput("burst_we", cfg_we, 1);
        checkOutput("burst_addr31", cfg_addr, 31);
        checkOutput("burst_wdata", cfg_wdata, 8'h3C);
        idleCycle();
        checkOutput("burst_addr_wrap", cfg_addr, 0);

        // Spike on channel 9 seen on page 1
        applyStimulus(1, 0, 8'h00, 12'h200);
        idleCycle();
        applyStimulus(1, 1, 8'h61, '0);
        idleCycle();
        idleCycle();
        checkOutput("page1_spike9", uo_out, 8'h02);
        applyStimulus(1, 1, 8'h60, '0);
        idleCycle();
        idleCycle();
        checkOutput("page0_empty", uo_out, 8'h00);
        checkOutput("spike_any", uio_out[3], 1);

        // CLEAR colliding with a new spike on channel 3
        applyStimulus(1, 1, 8'hC0, 12'h008);
        idleCycle();
        idleCycle();
        checkOutput("clear_new_spike", uo_out, 8'h08);

        // ena low blocks commands and holds WAIT_DATA
        applyStimulus(0, 1, 8'h81, '0);
        idleCycle();
        checkOutput("ena_low_run", run_en, 0);
        applyStimulus(1, 1, 8'h40, '0);
        applyStimulus(0, 1, 8'h77, '0);
        applyStimulus(0, 1, 8'h77, '0);
        checkOutput("ena_low_no_we", cfg_we, 0);
        checkOutput("ena_low_wait", uio_out[1], 1);
        applyStimulus(1, 1, 8'h11, '0);
        idleCycle();
        checkOutput("ena_we", cfg_we, 1);
        checkOutput("ena_wdata", cfg_wdata, 8'h11);
        idleCycle();

        // STEP pulse lasts exactly one cycle
        applyStimulus(1, 1, 8'hA0, '0);
        idleCycle();
        checkOutput("step_high", step, 1);
        idleCycle();
        checkOutput("step_low", step, 0);

        // Readback opcode
        cfg_rdata = 8'h5A;
        applyStimulus(1, 1, 8'hE0, '0);
        idleCycle();
        idleCycle();
`ifdef SNPU_READBACK_EN
        checkOutput("read_data", uo_out, 8'h5A);
        checkOutput("read_mode_flag", uio_out[6], 1);
`else
        checkOutput("read_as_nop", uo_out, 8'h08);
`endif
        applyStimulus(1, 1, 8'h00, '0);
        idleCycle();
        idleCycle();
        checkOutput("nop_restores_page", uo_out, 8'h08);

        // Asynchronous reset mid-run
        applyStimulus(1, 1, 8'h81, '0);
        idleCycle();
        checkOutput("run_set", run_en, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_uo_out", uo_out, 8'h00);
        checkOutput("arst_run_en", run_en, 0);
        checkOutput("arst_uio_out", uio_out, 8'h00);
        checkOutput("arst_uio_oe", uio_oe, 8'hFE);
        checkOutput("arst_cfg_addr", cfg_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        repeat (800) begin
            cfg_rdata = 8'($urandom);
            applyStimulus(($urandom % 8) != 0, ($urandom % 3) != 0, 8'($urandom),
                          (($urandom % 6) == 0) ? N_CH'($urandom) : '0);
        end
        repeat (3) idleCycle();
        checkOutput("scoreboard_drained", wr_q.size() + step_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
